// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART receive controller: config FSM states,
// FIFO entry layout, and reset-time constants.
package uart_pkg;

    localparam int UART_DATA_BITS     = 8;
    localparam int DEFAULT_RESET_DIV  = 27;
    localparam int DEFAULT_QUIET_BITS = 11;

    typedef enum logic [1:0] {
        CFG_IDLE,
        CFG_WAIT,
        CFG_APPLY
    } cfg_state_e;

    typedef struct packed {
        logic [UART_DATA_BITS-1:0] data;
        logic                      perr;
        logic                      ferr;
    } fifo_entry_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous FIFO for received bytes. The head entry and valid flag are held in
// registers, so a write into an empty FIFO becomes visible on the following cycle.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  fifo_entry_t              wdata,
    input  logic                     pop,
    output fifo_entry_t              rdata,
    output logic                     valid,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    fifo_entry_t       mem_q [DEPTH];
    fifo_entry_t       mem_d [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]     count_q, count_d;
    fifo_entry_t       head_q, head_d;
    logic              valid_q, valid_d;
    logic              push_acc;
    logic              pop_acc;

    // A pop frees a slot, so a push into a full FIFO is accepted in the same cycle.
    always_comb begin
        pop_acc  = pop && (count_q != '0);
        push_acc = push && ((count_q != LW'(DEPTH)) || pop_acc);

        mem_d = mem_q;
        if (push_acc) begin
            mem_d[wr_ptr_q] = wdata;
        end

        wr_ptr_d = wr_ptr_q + AW'(push_acc);
        rd_ptr_d = rd_ptr_q + AW'(pop_acc);
        count_d  = count_q + LW'(push_acc) - LW'(pop_acc);
        valid_d  = (count_d != '0);

        head_d = '0;
        if (valid_d) begin
            if (push_acc && (wr_ptr_q == rd_ptr_d)) begin
                head_d = wdata;
            end else begin
                head_d = mem_q[rd_ptr_d];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
            valid_q  <= valid_d;
        end
    end

    assign rdata = head_q;
    assign valid = valid_q;
    assign full  = (count_q == LW'(DEPTH));
    assign level = count_q;

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: baud tick generation, quiet-line gated config changes,
// and a byte FIFO. Define UART_RX_CTRL_ERRCNT_EN to add saturating error counters.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = UART_DATA_BITS,
    parameter int OVS_FACTOR = 16,
    parameter int DIV_WIDTH  = 16,
    parameter int RESET_DIV  = DEFAULT_RESET_DIV,
    parameter int FIFO_DEPTH = 16,
    parameter int QUIET_BITS = DEFAULT_QUIET_BITS,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          cfg_valid,
    output logic                          cfg_ready,
    input  logic [DIV_WIDTH-1:0]          cfg_divisor,
    input  logic                          cfg_parity,
    output logic                          tick_16x,
    output logic                          parity_enable,
    input  logic                          rx_pin,
    input  logic [DATA_BITS-1:0]          rx_data,
    input  logic                          data_ready,
    input  logic                          parity_err,
    input  logic                          frame_err,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [DATA_BITS-1:0]          m_data,
    output logic                          m_perr,
    output logic                          m_ferr,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overrun,
    input  logic                          clear_stats
`ifdef UART_RX_CTRL_ERRCNT_EN
    ,
    output logic [CNT_WIDTH-1:0]          perr_count,
    output logic [CNT_WIDTH-1:0]          ferr_count,
    output logic [CNT_WIDTH-1:0]          ovr_count
`endif
);

    localparam int QUIET_TICKS = QUIET_BITS * OVS_FACTOR;
    localparam int QW          = $clog2(QUIET_TICKS + 1);

    cfg_state_e             state_q, state_d;
    logic [DIV_WIDTH-1:0]   pend_div_q, pend_div_d;
    logic                   pend_par_q, pend_par_d;
    logic [DIV_WIDTH-1:0]   act_div_q, act_div_d;
    logic                   act_par_q, act_par_d;
    logic [DIV_WIDTH-1:0]   tick_cnt_q, tick_cnt_d;
    logic [QW-1:0]          quiet_q, quiet_d;
    logic                   overrun_q, overrun_d;
    logic [DIV_WIDTH-1:0]   tick_max;
    logic                   apply;
    logic                   tick;

    fifo_entry_t            push_entry;
    fifo_entry_t            head;
    logic                   fifo_full;
    logic                   pop;
    logic                   drop;

    // Config FSM: a request is latched, then waits for QUIET_TICKS of idle line
    // before being committed in a single apply cycle.
    always_comb begin
        state_d    = state_q;
        pend_div_d = pend_div_q;
        pend_par_d = pend_par_q;
        act_div_d  = act_div_q;
        act_par_d  = act_par_q;
        quiet_d    = quiet_q;
        apply      = 1'b0;
        cfg_ready  = 1'b0;
        case (state_q)
            CFG_IDLE: begin
                cfg_ready = 1'b1;
                quiet_d   = '0;
                if (cfg_valid) begin
                    pend_div_d = cfg_divisor;
                    pend_par_d = cfg_parity;
                    state_d    = CFG_WAIT;
                end
            end
            CFG_WAIT: begin
                if (!rx_pin) begin
                    quiet_d = '0;
                end else if (tick && (quiet_q != QW'(QUIET_TICKS))) begin
                    quiet_d = quiet_q + QW'(1);
                end
                if (quiet_q == QW'(QUIET_TICKS)) begin
                    state_d = CFG_APPLY;
                end
            end
            CFG_APPLY: begin
                apply     = 1'b1;
                act_div_d = pend_div_q;
                act_par_d = pend_par_q;
                state_d   = CFG_IDLE;
            end
            default: begin
                state_d = CFG_IDLE;
            end
        endcase
    end

    // Divisor 0 shares the divisor-1 terminal count, giving a tick every cycle.
    always_comb begin
        tick_max = (act_div_q == '0) ? '0 : (act_div_q - DIV_WIDTH'(1));
        tick     = !apply && (tick_cnt_q == tick_max);
        if (apply || (tick_cnt_q == tick_max)) begin
            tick_cnt_d = '0;
        end else begin
            tick_cnt_d = tick_cnt_q + DIV_WIDTH'(1);
        end
    end

    always_comb begin
        push_entry.data = rx_data;
        push_entry.perr = parity_err;
        push_entry.ferr = frame_err;
        pop             = m_valid && m_ready;
        drop            = data_ready && fifo_full && !pop;
        overrun_d       = overrun_q;
        if (clear_stats) begin
            overrun_d = 1'b0;
        end else if (drop) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= CFG_IDLE;
            pend_div_q <= DIV_WIDTH'(RESET_DIV);
            pend_par_q <= 1'b0;
            act_div_q  <= DIV_WIDTH'(RESET_DIV);
            act_par_q  <= 1'b0;
            tick_cnt_q <= '0;
            quiet_q    <= '0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pend_div_q <= pend_div_d;
            pend_par_q <= pend_par_d;
            act_div_q  <= act_div_d;
            act_par_q  <= act_par_d;
            tick_cnt_q <= tick_cnt_d;
            quiet_q    <= quiet_d;
            overrun_q  <= overrun_d;
        end
    end

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (data_ready),
        .wdata (push_entry),
        .pop   (m_ready),
        .rdata (head),
        .valid (m_valid),
        .full  (fifo_full),
        .level (fifo_level)
    );

    assign m_data        = head.data;
    assign m_perr        = head.perr;
    assign m_ferr        = head.ferr;
    assign tick_16x      = tick;
    assign parity_enable = act_par_q;
    assign overrun       = overrun_q;

`ifdef UART_RX_CTRL_ERRCNT_EN
    logic [CNT_WIDTH-1:0] perr_cnt_q, perr_cnt_d;
    logic [CNT_WIDTH-1:0] ferr_cnt_q, ferr_cnt_d;
    logic [CNT_WIDTH-1:0] ovr_cnt_q, ovr_cnt_d;

    // Saturating counters; a same-cycle clear overrides any increment.
    always_comb begin
        perr_cnt_d = perr_cnt_q;
        ferr_cnt_d = ferr_cnt_q;
        ovr_cnt_d  = ovr_cnt_q;
        if (clear_stats) begin
            perr_cnt_d = '0;
            ferr_cnt_d = '0;
            ovr_cnt_d  = '0;
        end else begin
            if (data_ready && parity_err && (perr_cnt_q != '1)) begin
                perr_cnt_d = perr_cnt_q + CNT_WIDTH'(1);
            end
            if (data_ready && frame_err && (ferr_cnt_q != '1)) begin
                ferr_cnt_d = ferr_cnt_q + CNT_WIDTH'(1);
            end
            if (drop && (ovr_cnt_q != '1)) begin
                ovr_cnt_d = ovr_cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perr_cnt_q <= '0;
            ferr_cnt_q <= '0;
            ovr_cnt_q  <= '0;
        end else begin
            perr_cnt_q <= perr_cnt_d;
            ferr_cnt_q <= ferr_cnt_d;
            ovr_cnt_q  <= ovr_cnt_d;
        end
    end

    assign perr_count = perr_cnt_q;
    assign ferr_count = ferr_cnt_q;
    assign ovr_count  = ovr_cnt_q;
`else
    // Without the counters only the sticky overrun flag records dropped bytes.
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed self-checking bench for uart_rx_ctrl: reset, config gating, FIFO
// ordering, overflow, clear_stats priority and asynchronous reset.
module tb_uart_rx_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [15:0] cfg_divisor;
    logic        cfg_parity;
    logic        tick_16x;
    logic        parity_enable;
    logic        rx_pin;
    logic [7:0]  rx_data;
    logic        data_ready;
    logic        parity_err;
    logic        frame_err;
    logic        m_valid;
    logic        m_ready;
    logic [7:0]  m_data;
    logic        m_perr;
    logic        m_ferr;
    logic [4:0]  fifo_level;
    logic        overrun;
    logic        clear_stats;
`ifdef UART_RX_CTRL_ERRCNT_EN
    logic [15:0] perr_count;
    logic [15:0] ferr_count;
    logic [15:0] ovr_count;
`endif

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    uart_rx_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready),
        .cfg_divisor   (cfg_divisor),
        .cfg_parity    (cfg_parity),
        .tick_16x      (tick_16x),
        .parity_enable (parity_enable),
        .rx_pin        (rx_pin),
        .rx_data       (rx_data),
        .data_ready    (data_ready),
        .parity_err    (parity_err),
        .frame_err     (frame_err),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_data        (m_data),
        .m_perr        (m_perr),
        .m_ferr        (m_ferr),
        .fifo_level    (fifo_level),
        .overrun       (overrun),
        .clear_stats   (clear_stats)
`ifdef UART_RX_CTRL_ERRCNT_EN
        ,
        .perr_count    (perr_count),
        .ferr_count    (ferr_count),
        .ovr_count     (ovr_count)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Returns cycles until the next tick seen at a negedge, or -1 on timeout.
    task automatic wait_tick(input int max_cycles, output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (tick_16x !== 1'b1 && cycles < max_cycles);
        if (tick_16x !== 1'b1) cycles = -1;
    endtask

    task automatic push_byte(input logic [7:0] d, input logic pe, input logic fe);
        data_ready = 1'b1;
        rx_data    = d;
        parity_err = pe;
        frame_err  = fe;
        step();
        data_ready = 1'b0;
        parity_err = 1'b0;
        frame_err  = 1'b0;
        step();
    endtask

    task automatic do_cfg(input logic [15:0] div, input logic par);
        cfg_valid   = 1'b1;
        cfg_divisor = div;
        cfg_parity  = par;
        step();
        cfg_valid   = 1'b0;
    endtask

    task automatic test_reset();
        int p;
        reset = 1'b1;
        #12;
        checks++; if (cfg_ready !== 1'b1) $display("[TB] FAIL reset_cfg_ready: got %b want 1", cfg_ready); else passed++;
        checks++; if (parity_enable !== 1'b0) $display("[TB] FAIL reset_parity: got %b want 0", parity_enable); else passed++;
        checks++; if (m_valid !== 1'b0) $display("[TB] FAIL reset_m_valid: got %b want 0", m_valid); else passed++;
        checks++; if (fifo_level !== 5'd0) $display("[TB] FAIL reset_level: got %0d want 0", fifo_level); else passed++;
        checks++; if (tick_16x !== 1'b0) $display("[TB] FAIL reset_tick: got %b want 0", tick_16x); else passed++;
        checks++; if ({overrun, m_data, m_perr, m_ferr} !== 11'd0) $display("[TB] FAIL reset_head: got %h want 0", {overrun, m_data, m_perr, m_ferr}); else passed++;
        step();
        reset = 1'b0;
        wait_tick(100, p);
        wait_tick(100, p);
        checks++; if (p !== 27) $display("[TB] FAIL reset_tick_period: got %0d want 27", p); else passed++;
        step();
    endtask

    task automatic test_config_apply();
        int  n, cyc, p;
        bit  ready_seen;
        do_cfg(16'd4, 1'b1);
        @(negedge clk);
        checks++; if (cfg_ready !== 1'b0) $display("[TB] FAIL cfg_busy: got %b want 0", cfg_ready); else passed++;
        step();
        ready_seen = 1'b0;
        for (int k = 0; k < 30; k++) begin
            rx_pin = ~rx_pin;
            for (int c = 0; c < 100; c++) begin
                step();
                if (cfg_ready === 1'b1 || parity_enable === 1'b1) ready_seen = 1'b1;
            end
        end
        rx_pin = 1'b0;
        repeat (10) step();
        checks++; if (ready_seen !== 1'b0 || parity_enable !== 1'b0) $display("[TB] FAIL cfg_no_apply_toggling: got applied=%b want 0", ready_seen | parity_enable); else passed++;
        rx_pin = 1'b1;
        n = 0;
        cyc = 0;
        while (parity_enable !== 1'b1 && cyc < 6000) begin
            @(negedge clk);
            cyc++;
            if (tick_16x === 1'b1 && parity_enable !== 1'b1) n++;
        end
        checks++; if (parity_enable !== 1'b1) $display("[TB] FAIL cfg_apply_parity: got %b want 1", parity_enable); else passed++;
        checks++; if (n !== 176) $display("[TB] FAIL cfg_quiet_ticks: got %0d want 176", n); else passed++;
        wait_tick(20, p);
        checks++; if (p !== 3) $display("[TB] FAIL cfg_first_tick: got %0d want 3 cycles after parity change", p); else passed++;
        wait_tick(20, p);
        checks++; if (p !== 4) $display("[TB] FAIL cfg_new_period: got %0d want 4", p); else passed++;
        checks++; if (cfg_ready !== 1'b1) $display("[TB] FAIL cfg_ready_after_apply: got %b want 1", cfg_ready); else passed++;
        step();
    endtask

    task automatic test_fifo_order();
        logic [7:0] exp_d [3] = '{8'h11, 8'h22, 8'h33};
        logic       exp_p [3] = '{1'b0, 1'b1, 1'b0};
        logic       exp_f [3] = '{1'b0, 1'b0, 1'b1};
        m_ready    = 1'b0;
        data_ready = 1'b1;
        rx_data    = 8'h11;
        @(negedge clk);
        checks++; if (m_valid !== 1'b0) $display("[TB] FAIL fifo_no_fallthrough: got %b want 0", m_valid); else passed++;
        step();
        data_ready = 1'b0;
        @(negedge clk);
        checks++; if (m_valid !== 1'b1 || m_data !== 8'h11) $display("[TB] FAIL fifo_first_visible: got v=%b d=%h want v=1 d=11", m_valid, m_data); else passed++;
        step();
        push_byte(8'h22, 1'b1, 1'b0);
        push_byte(8'h33, 1'b0, 1'b1);
        @(negedge clk);
        checks++; if (fifo_level !== 5'd3) $display("[TB] FAIL fifo_level3: got %0d want 3", fifo_level); else passed++;
        checks++; if (m_data !== 8'h11) $display("[TB] FAIL fifo_head_hold: got %h want 11", m_data); else passed++;
        step();
        m_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (m_valid !== 1'b1 || m_data !== exp_d[i] || m_perr !== exp_p[i] || m_ferr !== exp_f[i] || fifo_level !== 5'(3 - i))
                $display("[TB] FAIL fifo_pop%0d: got v=%b d=%h p=%b f=%b lvl=%0d want v=1 d=%h p=%b f=%b lvl=%0d",
                         i, m_valid, m_data, m_perr, m_ferr, fifo_level, exp_d[i], exp_p[i], exp_f[i], 3 - i);
            else passed++;
            step();
        end
        m_ready = 1'b0;
        @(negedge clk);
        checks++; if (m_valid !== 1'b0 || fifo_level !== 5'd0) $display("[TB] FAIL fifo_empty: got v=%b lvl=%0d want v=0 lvl=0", m_valid, fifo_level); else passed++;
        step();
    endtask

    task automatic test_overflow();
        logic [7:0] first_d, last_d;
        m_ready = 1'b0;
        for (int i = 0; i < 17; i++) push_byte(8'h40 + 8'(i), 1'b0, 1'b0);
        @(negedge clk);
        checks++; if (fifo_level !== 5'd16) $display("[TB] FAIL ovf_level: got %0d want 16", fifo_level); else passed++;
        checks++; if (overrun !== 1'b1) $display("[TB] FAIL ovf_overrun: got %b want 1", overrun); else passed++;
        checks++; if (m_data !== 8'h40) $display("[TB] FAIL ovf_head: got %h want 40", m_data); else passed++;
`ifdef UART_RX_CTRL_ERRCNT_EN
        checks++; if (ovr_count !== 16'd1) $display("[TB] FAIL ovf_count: got %0d want 1", ovr_count); else passed++;
`endif
        step();
        data_ready = 1'b1;
        rx_data    = 8'hEE;
        m_ready    = 1'b1;
        step();
        data_ready = 1'b0;
        m_ready    = 1'b0;
        @(negedge clk);
        checks++; if (fifo_level !== 5'd16 || m_data !== 8'h41) $display("[TB] FAIL ovf_push_pop: got lvl=%0d d=%h want lvl=16 d=41", fifo_level, m_data); else passed++;
`ifdef UART_RX_CTRL_ERRCNT_EN
        checks++; if (ovr_count !== 16'd1) $display("[TB] FAIL ovf_count_hold: got %0d want 1", ovr_count); else passed++;
`endif
        step();
        m_ready = 1'b1;
        first_d = 8'h00;
        last_d  = 8'h00;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (i == 0) first_d = m_data;
            if (i == 15) last_d = m_data;
            step();
        end
        m_ready = 1'b0;
        @(negedge clk);
        checks++; if (first_d !== 8'h41 || last_d !== 8'hEE) $display("[TB] FAIL ovf_drain: got first=%h last=%h want 41 EE", first_d, last_d); else passed++;
        checks++; if (fifo_level !== 5'd0) $display("[TB] FAIL ovf_drained_level: got %0d want 0", fifo_level); else passed++;
        step();
    endtask

    task automatic test_clear_stats();
`ifdef UART_RX_CTRL_ERRCNT_EN
        @(negedge clk);
        checks++; if (perr_count !== 16'd1 || ferr_count !== 16'd1) $display("[TB] FAIL stat_counts: got p=%0d f=%0d want 1 1", perr_count, ferr_count); else passed++;
        step();
`endif
        data_ready  = 1'b1;
        rx_data     = 8'h5A;
        parity_err  = 1'b1;
        clear_stats = 1'b1;
        step();
        data_ready  = 1'b0;
        parity_err  = 1'b0;
        clear_stats = 1'b0;
        @(negedge clk);
        checks++; if (overrun !== 1'b0) $display("[TB] FAIL clr_overrun: got %b want 0", overrun); else passed++;
        checks++; if (m_valid !== 1'b1 || m_data !== 8'h5A || m_perr !== 1'b1) $display("[TB] FAIL clr_byte_kept: got v=%b d=%h p=%b want 1 5A 1", m_valid, m_data, m_perr); else passed++;
`ifdef UART_RX_CTRL_ERRCNT_EN
        checks++; if (perr_count !== 16'd0 || ovr_count !== 16'd0) $display("[TB] FAIL clr_counts: got p=%0d o=%0d want 0 0", perr_count, ovr_count); else passed++;
`endif
        step();
        push_byte(8'h5B, 1'b1, 1'b0);
        @(negedge clk);
        checks++; if (fifo_level !== 5'd2) $display("[TB] FAIL clr_level: got %0d want 2", fifo_level); else passed++;
`ifdef UART_RX_CTRL_ERRCNT_EN
        checks++; if (perr_count !== 16'd1) $display("[TB] FAIL clr_recount: got %0d want 1", perr_count); else passed++;
`endif
        step();
        m_ready = 1'b1;
        repeat (2) step();
        m_ready = 1'b0;
    endtask

    task automatic test_div_zero();
        int p, cyc;
        do_cfg(16'd0, 1'b0);
        cyc = 0;
        while (cfg_ready !== 1'b1 && cyc < 2000) begin
            step();
            cyc++;
        end
        checks++; if (cfg_ready !== 1'b1 || parity_enable !== 1'b0) $display("[TB] FAIL div0_apply: got ready=%b par=%b want 1 0", cfg_ready, parity_enable); else passed++;
        wait_tick(10, p);
        wait_tick(10, p);
        checks++; if (p !== 1) $display("[TB] FAIL div0_period: got %0d want 1", p); else passed++;
        step();
    endtask

    task automatic test_reset_mid_config();
        int p;
        for (int i = 0; i < 5; i++) push_byte(8'hA0 + 8'(i), 1'b0, 1'b0);
        do_cfg(16'd9, 1'b1);
        repeat (20) step();
        @(negedge clk);
        checks++; if (cfg_ready !== 1'b0 || fifo_level !== 5'd5) $display("[TB] FAIL rst_setup: got ready=%b lvl=%0d want 0 5", cfg_ready, fifo_level); else passed++;
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        checks++; if (fifo_level !== 5'd0 || m_valid !== 1'b0 || m_data !== 8'h00) $display("[TB] FAIL rst_async_fifo: got lvl=%0d v=%b d=%h want 0 0 00", fifo_level, m_valid, m_data); else passed++;
        checks++; if (cfg_ready !== 1'b1 || parity_enable !== 1'b0 || tick_16x !== 1'b0 || overrun !== 1'b0) $display("[TB] FAIL rst_async_ctrl: got ready=%b par=%b tick=%b ovr=%b want 1 0 0 0", cfg_ready, parity_enable, tick_16x, overrun); else passed++;
        step();
        reset = 1'b0;
        wait_tick(100, p);
        wait_tick(100, p);
        checks++; if (p !== 27) $display("[TB] FAIL rst_divisor: got %0d want 27", p); else passed++;
    endtask

    initial begin
        reset       = 1'b1;
        cfg_valid   = 1'b0;
        cfg_divisor = 16'd0;
        cfg_parity  = 1'b0;
        rx_pin      = 1'b1;
        rx_data     = 8'h00;
        data_ready  = 1'b0;
        parity_err  = 1'b0;
        frame_err   = 1'b0;
        m_ready     = 1'b0;
        clear_stats = 1'b0;
        test_reset();
        test_config_apply();
        test_fifo_order();
        test_overflow();
        test_clear_stats();
        test_div_zero();
        test_reset_mid_config();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Controller that sequences and serves the UART receiver. It generates the receiver's 16x oversample tick from a programmable baud divisor and owns the receiver's parity configuration. Configuration changes apply only once the line has been quiet. Received bytes and their error flags are buffered in a FIFO behind a valid/ready consumer port. It sits between the receiver and the bus-side register block.

## Interface
- DATA_BITS, 8, data width of the receiver
- OVS_FACTOR, 16, oversample ticks per bit
- DIV_WIDTH, 16, baud divisor width
- RESET_DIV, 27, divisor loaded at reset
- FIFO_DEPTH, 16, FIFO entries; power of two, ≥2
- QUIET_BITS, 11, idle bit-times required before a config change applies
- CNT_WIDTH, 16, error counter width
- Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- cfg_valid  in  1  config request
- cfg_ready  out  1  config accepted when high with cfg_valid
- cfg_divisor  in  DIV_WIDTH  new baud divisor
- cfg_parity  in  1  new parity enable
- tick_16x  out  1  oversample tick to receiver
- parity_enable  out  1  active parity setting to receiver
- rx_pin  in  1  serial line, monitored for quiet detection
- rx_data  in  DATA_BITS  receiver byte
- data_ready  in  1  receiver byte-valid pulse
- parity_err  in  1  receiver parity flag
- frame_err  in  1  receiver framing flag
- m_valid  out  1  FIFO head valid
- m_ready  in  1  consumer accept
- m_data  out  DATA_BITS  head byte
- m_perr  out  1  head parity flag
- m_ferr  out  1  head framing flag
- fifo_level  out  $clog2(FIFO_DEPTH)+1  entries held
- overrun  out  1  sticky: byte dropped on full FIFO
- clear_stats  in  1  clears overrun and counters

## Operation
- Reset: active divisor = RESET_DIV, parity_enable=0, FIFO empty, m_valid=0, m_data/m_perr/m_ferr=0, fifo_level=0, overrun=0, tick_16x=0, cfg_ready=1, counters=0, config FSM in CFG_IDLE. A reset mid-frame or mid-config discards all state.
- Tick generator: counter 0..max(div,1)-1. tick_16x pulses one cycle when the counter wraps. Divisor 0 behaves as 1, which ticks every cycle. The counter is cleared on config apply.
- Config FSM:
  - CFG_IDLE: cfg_ready=1. cfg_valid captures cfg_divisor/cfg_parity into pending registers and moves to CFG_WAIT.
  - CFG_WAIT: cfg_ready=0. The quiet counter increments on each tick_16x while rx_pin=1 and clears whenever rx_pin=0. At QUIET_BITS*OVS_FACTOR the FSM moves to CFG_APPLY.
  - CFG_APPLY: for one cycle, loads the active divisor/parity from pending, clears the tick counter, and returns to CFG_IDLE.
- FIFO push: on data_ready, the entry {rx_data, parity_err, frame_err} is pushed. Bytes with errors are pushed too.
- FIFO full: the push is dropped, overrun is set, and ovr_count increments.
- Full FIFO with a pop in the same cycle: the push is accepted and the level is unchanged.
- FIFO pop: on m_valid && m_ready. Head outputs hold stable while m_valid && !m_ready.
- clear_stats: clears overrun and all counters. If clear_stats and an error event occur in the same cycle, the clear wins.

## Timing
- data_ready at cycle N: m_valid=1 at N+1 when the FIFO was empty. There is no fall-through.
- Pop at N: the next entry is on m_data at N+1, and fifo_level updates at N+1.
- cfg handshake at N: CFG_WAIT from N+1. The apply cycle is followed by the first tick under the new divisor exactly max(new_div,1) cycles later.
- Counters and overrun update one cycle after the qualifying data_ready.

## Configuration
- UART_RX_CTRL_ERRCNT_EN defined:
  - Adds outputs perr_count, ferr_count, ovr_count, each CNT_WIDTH wide.
  - perr_count increments on data_ready && parity_err.
  - ferr_count increments on data_ready && frame_err.
  - ovr_count increments on each dropped byte.
  - All three saturate at all-ones and are cleared by reset and clear_stats.
- Undefined: these ports and their logic are absent. The overrun flag remains.

## Structure
- Package uart_pkg: the config FSM enum (CFG_IDLE, CFG_WAIT, CFG_APPLY), the FIFO entry struct {data, perr, ferr}, and the default constants for RESET_DIV and QUIET_BITS.
- Sub-module uart_rx_fifo: synchronous FIFO with level output and push/pop/full/empty. Registered outputs are required.

## Test plan
- Reset, then count clocks between ticks: period is 27 cycles, parity_enable=0, cfg_ready=1, m_valid=0.
- cfg_divisor=4, cfg_parity=1 while rx_pin toggles every 100 cycles: no apply occurs. Then hold rx_pin high: apply after 176 ticks, tick period becomes 4, and parity_enable=1.
- Three data_ready pulses (0x11, 0x22 with parity_err, 0x33 with frame_err) with m_ready=0: fifo_level=3. Then set m_ready=1: pops yield 0x11/0/0, 0x22/1/0, 0x33/0/1 in order.
- 17 data_ready pulses with no pop: 16 stored, overrun=1, and ovr_count=1 when the macro is enabled. A pop concurrent with a push on the full FIFO keeps the level at 16.
- clear_stats in the same cycle as a parity-error byte: overrun=0 and perr_count=0, and the byte is still queued with m_perr=1.
- Async reset asserted during CFG_WAIT with 5 entries queued: all outputs return to reset values and the divisor is 27.
